ghost_motion_stage: RTL and testbench
=====================================

// Module: ghost_motion_stage
// PURPOSE
//  Downstream stage of each ghost control FSM. Takes the proposed next_x/next_y and ghost_direction
//  once per movement tick and checks the target tile against tilemap_walls.
//  Commits the move or holds position, then registers the ghost's x/y. Those x/y feed back into the
//  ghost control block and go out to the renderer.
//  Also flags ghost/pac-man overlap for the game FSM.
// PARAMETERS
//  START_X    260  x loaded on reset (pixels)
//  START_Y    240  y loaded on reset (pixels)
//  TILE_SIZE  20   tile edge in pixels; index divisor for wall lookup
// PORTS
//  clk              in   1                                  system clock
//  reset            in   1                                  async, active-low
//  tick             in   1                                  movement-rate pulse, 1 clk wide
//  next_x           in   $clog2(`WIDTH)                     proposed x from ghost control
//  next_y           in   $clog2(`HEIGHT)                    proposed y from ghost control
//  ghost_direction  in   2                                  `dir_up/down/left/right of proposal
//  tilemap_walls    in   `tile_row_num*`tile_col_num        1 = wall; idx = row*`tile_col_num+col
//  pac_x            in   $clog2(`WIDTH)                     pac-man x
//  pac_y            in   $clog2(`HEIGHT)                    pac-man y
//  x                out  $clog2(`WIDTH)                     committed ghost x
//  y                out  $clog2(`HEIGHT)                    committed ghost y
//  moved            out  1                                  1-clk pulse: position changed
//  blocked          out  1                                  1-clk pulse: proposal rejected
//  caught           out  1                                  level: x==pac_x && y==pac_y
// BEHAVIOUR
//  Reset (async, reset==0):
//   - x=START_X, y=START_Y, moved=0, blocked=0, caught=0, state=S_WAIT.
//   - Reset asserted mid-move aborts the pending move; no partial commit.
//  FSM: S_WAIT -> S_CHECK -> S_COMMIT -> S_WAIT.
//   - S_WAIT: on tick=1, latch cand_x/cand_y/cand_dir from the inputs and go to S_CHECK.
//     Without a tick, stay in S_WAIT.
//   - S_CHECK: perform the bounds test, then the wall lookup, both registered into ok_r.
//     - Bounds test: cand_x>=`WIDTH or cand_y>=`HEIGHT means out of bounds.
//       Unsigned underflow (0-20) lands here.
//     - Wall lookup: col=cand_x/TILE_SIZE, row=cand_y/TILE_SIZE, bit tilemap_walls[row*`tile_col_num+col].
//     - ok_r = in-bounds && !wall.
//   - S_COMMIT, ok_r=1: x<=cand_x, y<=cand_y.
//     moved=1 only if the new position differs from the old one.
//   - S_COMMIT, ok_r=0: hold x/y, pulse blocked=1.
//  Latency: tick to updated x/y is 3 clk. The next tick is accepted at the earliest 3 clk after the previous one.
//  A tick arriving in S_CHECK or S_COMMIT is ignored (dropped, not queued).
//  moved and blocked are never both 1. Each is high for exactly one clk.
//  caught: registered compare of the current x/y against pac_x/pac_y, evaluated every clk in every state.
//   Reflects a commit 1 clk after x/y update.
//  tilemap_walls is sampled only in S_CHECK; changes in other states have no effect on the pending move.
//  Width rule: the index product uses $clog2(`tile_row_num*`tile_col_num) bits.
//   An out-of-bounds candidate never indexes the map.
// CONFIGURATION
//  GHOST_TUNNEL_WRAP_EN defined:
//   - An out-of-bounds x whose cand_dir is `dir_left becomes cand_x=`WIDTH-TILE_SIZE.
//     One whose cand_dir is `dir_right becomes cand_x=0.
//   - The wrapped position then gets the normal wall lookup.
//   - Out-of-bounds y is still blocked.
//  Not defined: every out-of-bounds candidate is blocked.
// TESTING
//  1. Reset: reset low async mid-clk -> x=260,y=240, moved=blocked=caught=0 without clk edge.
//  2. Open move: map all 0, next=(280,240) dir right, tick -> 3 clk later x=280, moved=1 for 1 clk.
//  3. Wall: set wall bit at tile (row12,col14), next=(280,240), tick -> x/y hold 260/240, blocked=1 for 1 clk.
//  4. Tick storm: tick high on 3 consecutive clk -> only the first is accepted; one commit.
//  5. Edge: x=0, next_x=0-20 dir left -> blocked without the macro; with GHOST_TUNNEL_WRAP_EN, x=`WIDTH-20.
//  6. Catch: pac=(280,240), commit move to (280,240) -> caught=1 one clk after x update.
//     Move away -> caught=0.

Source files
------------

// File: rtl/ghost_motion_stage.sv
// Ghost motion stage: validates a proposed ghost move against bounds and the wall map, then commits or holds.
// Optional build macro GHOST_TUNNEL_WRAP_EN wraps horizontal out-of-bounds moves to the opposite edge.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef TILE_ROW_NUM
`define TILE_ROW_NUM 24
`endif
`ifndef TILE_COL_NUM
`define TILE_COL_NUM 32
`endif
`ifndef DIR_UP
`define DIR_UP 2'd0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN 2'd1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT 2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module ghost_motion_stage #(
  parameter int START_X   = 260,
  parameter int START_Y   = 240,
  parameter int TILE_SIZE = 20
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      tick,
  input  logic [$clog2(`WIDTH)-1:0]                 next_x,
  input  logic [$clog2(`HEIGHT)-1:0]                next_y,
  input  logic [1:0]                                ghost_direction,
  input  logic [`TILE_ROW_NUM*`TILE_COL_NUM-1:0]    tilemap_walls,
  input  logic [$clog2(`WIDTH)-1:0]                 pac_x,
  input  logic [$clog2(`HEIGHT)-1:0]                pac_y,
  output logic [$clog2(`WIDTH)-1:0]                 x,
  output logic [$clog2(`HEIGHT)-1:0]                y,
  output logic                                      moved,
  output logic                                      blocked,
  output logic                                      caught
);
  localparam int XW   = $clog2(`WIDTH);
  localparam int YW   = $clog2(`HEIGHT);
  localparam int COLS = `TILE_COL_NUM;
  localparam int IW   = $clog2(`TILE_ROW_NUM * `TILE_COL_NUM);

  localparam logic [XW:0]   X_LIM  = (XW+1)'(`WIDTH);
  localparam logic [YW:0]   Y_LIM  = (YW+1)'(`HEIGHT);
  localparam logic [XW-1:0] TS_X   = XW'(TILE_SIZE);
  localparam logic [YW-1:0] TS_Y   = YW'(TILE_SIZE);
  localparam logic [IW-1:0] COLS_I = IW'(COLS);

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] cand_x_q, cand_x_d, x_q, x_d;
  logic [YW-1:0] cand_y_q, cand_y_d, y_q, y_d;
  logic [1:0]    cand_dir_q, cand_dir_d;
  logic          ok_q, ok_d;
  logic          moved_q, moved_d, blocked_q, blocked_d, caught_q, caught_d;

  logic [XW-1:0] chk_x, col;
  logic [YW-1:0] row;
  logic [IW-1:0] idx;
  logic          x_oob, y_oob, in_bounds, wall, chk_ok;

  // Bounds test first; the map is only indexed once the candidate is known to be on screen.
  always_comb begin
    chk_x = cand_x_q;
    x_oob = {1'b0, cand_x_q} >= X_LIM;
    y_oob = {1'b0, cand_y_q} >= Y_LIM;
`ifdef GHOST_TUNNEL_WRAP_EN
    if (x_oob && cand_dir_q == `DIR_LEFT) begin
      chk_x = XW'(`WIDTH - TILE_SIZE);
      x_oob = 1'b0;
    end else if (x_oob && cand_dir_q == `DIR_RIGHT) begin
      chk_x = '0;
      x_oob = 1'b0;
    end
`endif
    in_bounds = !x_oob && !y_oob;
    col       = chk_x / TS_X;
    row       = cand_y_q / TS_Y;
    idx       = in_bounds ? (IW'(row) * COLS_I + IW'(col)) : '0;
    wall      = in_bounds && tilemap_walls[idx];
    chk_ok    = in_bounds && !wall;
  end

`ifndef GHOST_TUNNEL_WRAP_EN
  // Direction only influences the tunnel wrap.
  logic unused_dir;
  assign unused_dir = ^cand_dir_q;
`endif

  always_comb begin
    state_d    = state_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    cand_dir_d = cand_dir_q;
    ok_d       = ok_q;
    x_d        = x_q;
    y_d        = y_q;
    moved_d    = 1'b0;
    blocked_d  = 1'b0;
    caught_d   = (x_q == pac_x) && (y_q == pac_y);
    case (state_q)
      S_WAIT: begin
        if (tick) begin
          cand_x_d   = next_x;
          cand_y_d   = next_y;
          cand_dir_d = ghost_direction;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        ok_d     = chk_ok;
        cand_x_d = chk_x;
        state_d  = S_COMMIT;
      end
      S_COMMIT: begin
        if (ok_q) begin
          x_d     = cand_x_q;
          y_d     = cand_y_q;
          moved_d = (cand_x_q != x_q) || (cand_y_q != y_q);
        end else begin
          blocked_d = 1'b1;
        end
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_WAIT;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      cand_dir_q <= '0;
      ok_q       <= 1'b0;
      x_q        <= XW'(START_X);
      y_q        <= YW'(START_Y);
      moved_q    <= 1'b0;
      blocked_q  <= 1'b0;
      caught_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      cand_dir_q <= cand_dir_d;
      ok_q       <= ok_d;
      x_q        <= x_d;
      y_q        <= y_d;
      moved_q    <= moved_d;
      blocked_q  <= blocked_d;
      caught_q   <= caught_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign moved   = moved_q;
  assign blocked = blocked_q;
  assign caught  = caught_q;

endmodule

// File: tb/tb_ghost_motion_stage.sv
// Directed bench for ghost_motion_stage: table of single moves plus hand sequences for
// tunnel edge, tick storm, wall sampling window and reset mid-move.
module tb_ghost_motion_stage;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int NW = 768;
  localparam int NCOL = 32;
  localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [XW-1:0] next_x, pac_x, x;
  logic [YW-1:0] next_y, pac_y, y;
  logic [1:0]    ghost_direction;
  logic [NW-1:0] tilemap_walls;
  logic          moved, blocked, caught;

  ghost_motion_stage dut (
    .clk(clk), .reset(reset), .tick(tick), .next_x(next_x), .next_y(next_y),
    .ghost_direction(ghost_direction), .tilemap_walls(tilemap_walls),
    .pac_x(pac_x), .pac_y(pac_y), .x(x), .y(y), .moved(moved), .blocked(blocked),
    .caught(caught)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cur_x  = 260;
  int cur_y  = 240;

  typedef struct {
    int nx; int ny; int dir;
    int wall_en; int wall_row; int wall_col;
    int px; int py;
    int exp_x; int exp_y; int exp_moved; int exp_blocked;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_move(input vec_t v, input string tag);
    logic old_caught;
    @(negedge clk);
    tilemap_walls = '0;
    if (v.wall_en != 0) tilemap_walls[v.wall_row*NCOL + v.wall_col] = 1'b1;
    next_x          = XW'(v.nx);
    next_y          = YW'(v.ny);
    ghost_direction = 2'(v.dir);
    pac_x           = XW'(v.px);
    pac_y           = YW'(v.py);
    tick            = 1'b1;
    old_caught      = (cur_x == v.px) && (cur_y == v.py);
    @(negedge clk);
    tick = 1'b0;
    @(posedge clk); #1;
    check({tag, " x_early"}, 32'(x), 32'(cur_x));
    check({tag, " moved_early"}, 32'(moved), 0);
    @(posedge clk); #1;
    check({tag, " x"}, 32'(x), 32'(v.exp_x));
    check({tag, " y"}, 32'(y), 32'(v.exp_y));
    check({tag, " moved"}, 32'(moved), 32'(v.exp_moved));
    check({tag, " blocked"}, 32'(blocked), 32'(v.exp_blocked));
    check({tag, " caught_old"}, 32'(caught), 32'(old_caught));
    @(posedge clk); #1;
    check({tag, " moved_clr"}, 32'(moved), 0);
    check({tag, " blocked_clr"}, 32'(blocked), 0);
    check({tag, " caught_new"}, 32'(caught),
          32'((v.exp_x == v.px) && (v.exp_y == v.py)));
    cur_x = v.exp_x;
    cur_y = v.exp_y;
  endtask

  initial begin
    vec_t v;
    //            nx   ny   dir      wall r   c   px   py   ex   ey   m  b
    vecs[0]  = '{280, 240, D_RIGHT, 1, 12, 14,   0,   0, 260, 240, 0, 1};
    vecs[1]  = '{280, 240, D_RIGHT, 0,  0,  0, 280, 240, 280, 240, 1, 0};
    vecs[2]  = '{300, 240, D_RIGHT, 0,  0,  0, 280, 240, 300, 240, 1, 0};
    vecs[3]  = '{300, 240, D_RIGHT, 0,  0,  0,   0,   0, 300, 240, 0, 0};
    vecs[4]  = '{300, 260, D_DOWN,  1, 13, 15,   0,   0, 300, 240, 0, 1};
    vecs[5]  = '{300, 480, D_DOWN,  0,  0,  0,   0,   0, 300, 240, 0, 1};
    vecs[6]  = '{639, 479, D_RIGHT, 0,  0,  0,   0,   0, 639, 479, 1, 0};
    vecs[7]  = '{  0,   0, D_UP,    0,  0,  0,   0,   0,   0,   0, 1, 0};
    vecs[8]  = '{639, 479, D_RIGHT, 1, 23, 31,   0,   0,   0,   0, 0, 1};
    vecs[9]  = '{ 40,  20, D_RIGHT, 1,  2,  1,   0,   0,  40,  20, 1, 0};
    vecs[10] = '{  0,   0, D_LEFT,  0,  0,  0,   0,   0,   0,   0, 1, 0};

    reset = 1'b1; tick = 1'b0; next_x = '0; next_y = '0; ghost_direction = '0;
    tilemap_walls = '0; pac_x = '0; pac_y = '0;

    // Asynchronous reset with no clock edge yet.
    #2 reset = 1'b0;
    #1;
    check("rst x", 32'(x), 260);
    check("rst y", 32'(y), 240);
    check("rst moved", 32'(moved), 0);
    check("rst blocked", 32'(blocked), 0);
    check("rst caught", 32'(caught), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) run_move(vecs[i], $sformatf("vec%0d", i));

    // Left tunnel edge from x=0.
`ifdef GHOST_TUNNEL_WRAP_EN
    v = '{1004, 0, D_LEFT, 0, 0, 0, 0, 0, 620, 0, 1, 0};
`else
    v = '{1004, 0, D_LEFT, 0, 0, 0, 0, 0,   0, 0, 0, 1};
`endif
    run_move(v, "edge_left");
    v = '{640, 0, D_RIGHT, 1, 0, 0, 0, 0, cur_x, cur_y, 0, 1};
    run_move(v, "edge_right_wall");
`ifdef GHOST_TUNNEL_WRAP_EN
    v = '{640, 0, D_RIGHT, 0, 0, 0, 0, 0, 0, 0, 1, 0};
`else
    v = '{640, 0, D_RIGHT, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`endif
    run_move(v, "edge_right");

    // Tick storm: three consecutive ticks, only the first proposal may commit.
    @(negedge clk);
    tilemap_walls = '0; ghost_direction = 2'(D_DOWN);
    next_x = 10'd100; next_y = 9'd100; tick = 1'b1;
    @(negedge clk);
    next_x = 10'd200; next_y = 9'd200;
    @(negedge clk);
    next_x = 10'd300; next_y = 9'd300;
    @(posedge clk); #1;
    check("storm x", 32'(x), 100);
    check("storm y", 32'(y), 100);
    check("storm moved", 32'(moved), 1);
    @(negedge clk);
    tick = 1'b0;
    @(posedge clk); #1;
    check("storm moved_clr", 32'(moved), 0);
    check("storm blocked_clr", 32'(blocked), 0);
    repeat (4) @(posedge clk);
    #1;
    check("storm x_hold", 32'(x), 100);
    check("storm y_hold", 32'(y), 100);

    // Wall present at tick but cleared before the check cycle: move commits.
    @(negedge clk);
    tilemap_walls = '0; tilemap_walls[5*NCOL + 6] = 1'b1;
    next_x = 10'd120; next_y = 9'd100; ghost_direction = 2'(D_RIGHT); tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; tilemap_walls = '0;
    @(negedge clk);
    tilemap_walls[5*NCOL + 6] = 1'b1;
    @(posedge clk); #1;
    check("wsample1 x", 32'(x), 120);
    check("wsample1 moved", 32'(moved), 1);
    check("wsample1 blocked", 32'(blocked), 0);

    // Wall absent at tick but present in the check cycle: move rejected.
    @(negedge clk);
    tilemap_walls = '0;
    next_x = 10'd140; next_y = 9'd100; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; tilemap_walls[5*NCOL + 7] = 1'b1;
    @(negedge clk);
    tilemap_walls = '0;
    @(posedge clk); #1;
    check("wsample2 x", 32'(x), 120);
    check("wsample2 moved", 32'(moved), 0);
    check("wsample2 blocked", 32'(blocked), 1);
    cur_x = 120; cur_y = 100;

    // Reset mid-move while caught is high: no commit, outputs back to start.
    @(negedge clk);
    pac_x = 10'd120; pac_y = 9'd100;
    @(negedge clk);
    check("pre_rst caught", 32'(caught), 1);
    next_x = 10'd160; next_y = 9'd100; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst x", 32'(x), 260);
    check("midrst y", 32'(y), 240);
    check("midrst moved", 32'(moved), 0);
    check("midrst blocked", 32'(blocked), 0);
    check("midrst caught", 32'(caught), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("postrst x", 32'(x), 260);
    check("postrst y", 32'(y), 240);
    check("postrst moved", 32'(moved), 0);
    check("postrst caught", 32'(caught), 0);
    cur_x = 260; cur_y = 240;

    v = '{160, 100, D_RIGHT, 0, 0, 0, 160, 100, 160, 100, 1, 0};
    run_move(v, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
